pixel_plane_packer: RTL and testbench

PIXEL_PLANE_PACKER -- requirements
Module: pixel_plane_packer

---
 rtl/pixel_plane_packer.sv | 124 ++++++++++++
 tb/tb_pixel_plane_packer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plane_packer.sv
// Pixel plane packer: gathers eight 4-bit colour indices into one byte
// per bit-plane and hands each finished group to a ready/valid consumer.
//
// Ports:
//   clock, reset            - system clock, synchronous active-high reset
//   CE_PIXEL                - pixel-rate enable; gates SYNC, PIX_VALID, PIX, FLIP
//   SYNC                    - restart group alignment (drops any partial group)
//   PIX_VALID, PIX[3:0]     - pixel strobe and colour index (bit n -> plane n+1)
//   FLIP                    - horizontal flip, taken with a group's first pixel
//   OUT_READY               - consumer takes the held group (not gated by CE_PIXEL)
//   byte_1..byte_4          - packed planes 1..4 of the held group
//   OUT_VALID               - byte_1..byte_4 hold a complete group
//   OVERFLOW                - sticky: a finished group was dropped
//
// Build option: define PIXEL_PLANE_PACKER_PLANE4_EN to pack PIX[3] into
// byte_4; otherwise byte_4 is tied to 0x00 and plane 4 has no storage.

module pixel_plane_packer (
   input  logic       clock,
   input  logic       reset,
   input  logic       CE_PIXEL,
   input  logic       SYNC,
   input  logic       PIX_VALID,
   input  logic [3:0] PIX,
   input  logic       FLIP,
   input  logic       OUT_READY,
   output logic [7:0] byte_1,
   output logic [7:0] byte_2,
   output logic [7:0] byte_3,
   output logic [7:0] byte_4,
   output logic       OUT_VALID,
   output logic       OVERFLOW
);

`ifdef PIXEL_PLANE_PACKER_PLANE4_EN
   localparam int NP = 4;
`else
   localparam int NP = 3;
`endif

   logic [2:0]          cnt;
   logic                flip_q;
   logic [NP-1:0][7:0]  part;
   logic [NP-1:0][7:0]  nxt;
   logic [NP-1:0][7:0]  obyte;
   logic                ovalid;
   logic                ovf;

   logic                accept;
   logic                sync_en;
   logic                start;
   logic [2:0]          idx;
   logic                eff_flip;
   logic [2:0]          pos;
   logic                done;

   assign accept  = CE_PIXEL & PIX_VALID;
   assign sync_en = CE_PIXEL & SYNC;

   // A SYNC on the same edge as a pixel makes that pixel number 0.
   assign idx      = sync_en ? 3'd0 : cnt;
   assign start    = (idx == 3'd0);
   assign eff_flip = start ? FLIP : flip_q;
   assign pos      = eff_flip ? idx : (3'd7 - idx);
   assign done     = accept & (idx == 3'd7);

   // Partial planes with the current pixel merged in; a fresh group
   // starts from zero so stale bits of the previous group never leak.
   always_comb begin
      nxt = '0;
      for (int n = 0; n < NP; n++) begin
         nxt[n]      = start ? 8'h00 : part[n];
         nxt[n][pos] = PIX[n];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= 3'd0;
         flip_q <= 1'b0;
         part   <= '0;
         obyte  <= '0;
         ovalid <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (accept) begin
            part <= nxt;
            cnt  <= idx + 3'd1;
            if (start)
               flip_q <= FLIP;
         end else if (sync_en) begin
            part <= '0;
            cnt  <= 3'd0;
         end

         // The finishing pixel is packed straight from nxt, so the
         // group is visible on the outputs the very next cycle.
         if (done) begin
            if (!ovalid || OUT_READY) begin
               obyte  <= nxt;
               ovalid <= 1'b1;
            end else begin
               ovf <= 1'b1;
            end
         end else if (OUT_READY) begin
            ovalid <= 1'b0;
         end
      end
   end

   assign byte_1    = obyte[0];
   assign byte_2    = obyte[1];
   assign byte_3    = obyte[2];
`ifdef PIXEL_PLANE_PACKER_PLANE4_EN
   assign byte_4    = obyte[3];
`else
   logic unused_pix3;
   assign unused_pix3 = PIX[3];
   assign byte_4    = 8'h00;
`endif
   assign OUT_VALID = ovalid;
   assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_pixel_plane_packer.sv
// Self-checking bench for pixel_plane_packer: directed scenarios followed
// by randomized traffic compared against a group-level reference model.

module tb_pixel_plane_packer;

`ifdef PIXEL_PLANE_PACKER_PLANE4_EN
   localparam int NPL = 4;
   localparam logic [7:0] B4_80 = 8'h80;
`else
   localparam int NPL = 3;
   localparam logic [7:0] B4_80 = 8'h00;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       ce;
   logic       sync;
   logic       pv;
   logic [3:0] pix;
   logic       flip;
   logic       rdy;
   logic [7:0] b1, b2, b3, b4;
   logic       ovalid;
   logic       oflow;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [3:0] grp[$];
   logic       gflip;
   logic       m_valid;
   logic       m_ovf;
   logic [7:0] m_b[4];

   pixel_plane_packer dut (
      .clock     (clock),
      .reset     (reset),
      .CE_PIXEL  (ce),
      .SYNC      (sync),
      .PIX_VALID (pv),
      .PIX       (pix),
      .FLIP      (flip),
      .OUT_READY (rdy),
      .byte_1    (b1),
      .byte_2    (b2),
      .byte_3    (b3),
      .byte_4    (b4),
      .OUT_VALID (ovalid),
      .OVERFLOW  (oflow)
   );

   always #5 clock = ~clock;

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Group-level model: collect pixels, pack when eight have arrived.
   task automatic model(logic r, logic c, logic sy, logic v,
                        logic [3:0] px, logic fl, logic rd);
      logic       done;
      logic [7:0] nb[4];
      int         p;
      done = 1'b0;
      for (int n = 0; n < 4; n++) nb[n] = 8'h00;
      if (r) begin
         grp.delete();
         gflip   = 1'b0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         for (int n = 0; n < 4; n++) m_b[n] = 8'h00;
      end else begin
         if (c && sy) grp.delete();
         if (c && v) begin
            if (grp.size() == 0) gflip = fl;
            grp.push_back(px);
            if (grp.size() == 8) begin
               done = 1'b1;
               for (int k = 0; k < 8; k++)
                  for (int n = 0; n < NPL; n++) begin
                     p = gflip ? k : 7 - k;
                     nb[n][p] = grp[k][n];
                  end
               grp.delete();
            end
         end
         if (done) begin
            if (!m_valid || rd) begin
               m_b     = nb;
               m_valid = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end else if (rd) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step(string tag, logic r, logic c, logic sy, logic v,
                       logic [3:0] px, logic fl, logic rd);
      reset = r; ce = c; sync = sy; pv = v;
      pix = px; flip = fl; rdy = rd;
      @(posedge clock);
      model(r, c, sy, v, px, fl, rd);
      #1;
      chk({tag, ".valid"}, {7'b0, ovalid}, {7'b0, m_valid});
      chk({tag, ".ovf"},   {7'b0, oflow},  {7'b0, m_ovf});
      chk({tag, ".b1"}, b1, m_b[0]);
      chk({tag, ".b2"}, b2, m_b[1]);
      chk({tag, ".b3"}, b3, m_b[2]);
      chk({tag, ".b4"}, b4, m_b[3]);
   endtask

   task automatic pixel(string tag, logic [3:0] px, logic fl, logic rd);
      step(tag, 1'b0, 1'b1, 1'b0, 1'b1, px, fl, rd);
   endtask

   task automatic idle(string tag, logic rd);
      step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, rd);
   endtask

   task automatic do_reset(string tag);
      step(tag, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
      chk({tag, ".rst_valid"}, {7'b0, ovalid}, 8'h00);
      chk({tag, ".rst_ovf"},   {7'b0, oflow},  8'h00);
      chk({tag, ".rst_b1"}, b1, 8'h00);
      chk({tag, ".rst_b4"}, b4, 8'h00);
   endtask

   task automatic expect_group(string tag, logic [7:0] e1, logic [7:0] e2,
                               logic [7:0] e3, logic [7:0] e4);
      chk({tag, ".valid"}, {7'b0, ovalid}, 8'h01);
      chk({tag, ".b1"}, b1, e1);
      chk({tag, ".b2"}, b2, e2);
      chk({tag, ".b3"}, b3, e3);
      chk({tag, ".b4"}, b4, e4);
   endtask

   initial begin
      logic r, c, sy, v, fl, rd;
      logic [3:0] px;

      reset = 1'b1; ce = 1'b0; sync = 1'b0; pv = 1'b0;
      pix = 4'h0; flip = 1'b0; rdy = 1'b0;
      gflip = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
      for (int n = 0; n < 4; n++) m_b[n] = 8'h00;

      do_reset("reset");

      // ramp 0..7, no flip
      for (int k = 0; k < 8; k++) pixel("ramp", 4'(k), 1'b0, 1'b1);
      expect_group("ramp_grp", 8'h55, 8'h33, 8'h0F, 8'h00);
      idle("ramp_drain", 1'b1);
      chk("ramp_drained", {7'b0, ovalid}, 8'h00);

      // ramp with flip on pixel 0, FLIP toggling afterwards
      for (int k = 0; k < 8; k++)
         pixel("flip", 4'(k), (k == 0) ? 1'b1 : 1'(k), 1'b1);
      expect_group("flip_grp", 8'hAA, 8'hCC, 8'hF0, 8'h00);

      // CE_PIXEL low must freeze the packer
      pixel("ce0", 4'hF, 1'b0, 1'b1);
      step("ce_off", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
      for (int k = 1; k < 8; k++) pixel("ce0", 4'h0, 1'b1, 1'b1);
      expect_group("ce_grp", 8'h80, 8'h80, 8'h80, B4_80);

      // overflow: two groups with consumer stalled
      idle("ovf_pre", 1'b1);
      for (int k = 0; k < 8; k++) pixel("ovf_a", 4'(k), 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) pixel("ovf_b", 4'hF, 1'b0, 1'b0);
      expect_group("ovf_hold", 8'h55, 8'h33, 8'h0F, 8'h00);
      chk("ovf_set", {7'b0, oflow}, 8'h01);
      idle("ovf_drain", 1'b1);
      chk("ovf_drain_valid", {7'b0, ovalid}, 8'h00);
      chk("ovf_sticky", {7'b0, oflow}, 8'h01);

      // SYNC realigns mid-group
      do_reset("sync_rst");
      for (int k = 0; k < 3; k++) pixel("sync_pre", 4'hA, 1'b0, 1'b1);
      step("sync_px", 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) pixel("sync_post", 4'h0, 1'b1, 1'b1);
      chk("sync_no_early", {7'b0, ovalid}, 8'h00);
      pixel("sync_last", 4'h0, 1'b1, 1'b1);
      expect_group("sync_grp", 8'h80, 8'h80, 8'h80, B4_80);

      // reset mid-group
      idle("mid_pre", 1'b1);
      for (int k = 0; k < 5; k++) pixel("mid", 4'hF, 1'b0, 1'b1);
      do_reset("mid_rst");
      for (int k = 0; k < 7; k++) pixel("mid_new", 4'(k), 1'b0, 1'b1);
      chk("mid_not_yet", {7'b0, ovalid}, 8'h00);
      pixel("mid_new", 4'h7, 1'b0, 1'b1);
      expect_group("mid_grp", 8'h55, 8'h33, 8'h0F, 8'h00);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         c  = ($urandom_range(0, 3) != 0);
         sy = ($urandom_range(0, 24) == 0);
         v  = ($urandom_range(0, 4) != 0);
         px = 4'($urandom);
         fl = 1'($urandom);
         rd = ($urandom_range(0, 2) != 0);
         step("rand", r, c, sy, v, px, fl, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
